// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Sequential radix-2 shift-add multiplier. Operands are latched on an accepted
// start. One multiplier bit is retired per clock through a single WIDTH+1-bit
// adder, and the 2*WIDTH-bit product is written to o_p on the CALC->DONE
// transition. o_done pulses for one cycle. A start seen in DONE is accepted
// immediately, so operations can be issued back to back.
//
// Parameters:
//   WIDTH    operand width in bits (legal range 2..32); product is 2*WIDTH bits
//
// Optional build macro:
//   SEQ_MULT_SIGNED_EN  adds i_tc. With i_tc=1 the operands are two's
//                       complement. Magnitudes are multiplied and the product
//                       is negated when the operand signs differ.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous active-high reset
//   i_start  request, accepted on a rising edge while o_busy=0
//   i_a      multiplicand, latched on accept
//   i_b      multiplier, latched on accept
//   i_tc     (SEQ_MULT_SIGNED_EN only) two's-complement select, latched on accept
//   o_busy   high while in CALC
//   o_done   one-cycle pulse; o_p is valid from this cycle
//   o_p      product register, held until the next result is written
//
// States:
//   S_IDLE | waiting for start
//   S_CALC | one shift-add step per clock, WIDTH steps in total
//   S_DONE | o_done pulse; a start here is accepted as in S_IDLE
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic               i_tc,
`endif
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_p
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_p;

    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_addend;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic [WIDTH-1:0]     w_mplier_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_neg;

    // Operand conditioning at accept time
`ifdef SEQ_MULT_SIGNED_EN
    // The magnitude of the most-negative value (e.g. 128 for WIDTH=8) still
    // fits in WIDTH unsigned bits, so no extra width is needed.
    assign w_a_mag = (i_tc && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_b_mag = (i_tc && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_neg   = i_tc && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    assign w_final = r_neg ? -w_prod : w_prod;
`else
    assign w_a_mag = i_a;
    assign w_b_mag = i_b;
    assign w_neg   = 1'b0;
    assign w_final = w_prod;
`endif

    assign w_accept = i_start && (r_state != S_CALC);
    assign w_last   = (r_state == S_CALC) && (r_cnt == CNT_W'(1));

    // One shift-add step. The carry out of the add becomes the new acc MSB
    // after the right shift, and the bit leaving acc refills mplier from the top.
    assign w_addend     = r_mplier[0] ? r_mcand : '0;
    assign w_sum        = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_acc_nxt    = w_sum[WIDTH:1];
    assign w_mplier_nxt = {w_sum[0], r_mplier[WIDTH-1:1]};
    assign w_prod       = {w_acc_nxt, w_mplier_nxt};

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_p      <= '0;
        end else if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= CNT_W'(WIDTH);
            r_neg    <= w_neg;
        end else if (r_state == S_CALC) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= w_mplier_nxt;
            r_cnt    <= r_cnt - CNT_W'(1);
            if (w_last) begin
                r_p <= w_final;
            end
        end
    end

    assign o_p = r_p;

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic        clk;
    logic        rst;

    logic        start4;
    logic [3:0]  a4, b4;
    logic        busy4, done4;
    logic [7:0]  p4;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic [15:0] p8;
`ifdef SEQ_MULT_SIGNED_EN
    logic        tc4;
    logic        tc8;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start4),
        .i_a     (a4),
        .i_b     (b4),
`ifdef SEQ_MULT_SIGNED_EN
        .i_tc    (tc4),
`endif
        .o_busy  (busy4),
        .o_done  (done4),
        .o_p     (p4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start8),
        .i_a     (a8),
        .i_b     (b8),
`ifdef SEQ_MULT_SIGNED_EN
        .i_tc    (tc8),
`endif
        .o_busy  (busy8),
        .o_done  (done8),
        .o_p     (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed or unsigned product truncated to 2*WIDTH bits
    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input bit tc);
        int sa, sb, pr;
        sa = (tc && a[7]) ? int'(a) - 256 : int'(a);
        sb = (tc && b[7]) ? int'(b) - 256 : int'(b);
        pr = sa * sb;
        return pr[15:0];
    endfunction

    // Issue one WIDTH=4 operation from IDLE or DONE; returns in its DONE cycle.
    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int  k;
        bit  got;
        logic [7:0] exp;
        exp    = 8'(int'(a) * int'(b));
        a4     = a;
        b4     = b;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        k   = 0;
        got = 0;
        while (!got && k < 12) begin
            tick();
            k++;
            check("w4_busy_done_excl", {63'd0, busy4 & done4}, 64'd0);
            if (done4) got = 1;
            else check("w4_busy_in_calc", {63'd0, busy4}, 64'd1);
        end
        check("w4_latency", 64'(k), 64'd4);
        check("w4_product", {56'd0, p4}, {56'd0, exp});
    endtask

    // Issue one WIDTH=8 operation from IDLE or DONE; returns in its DONE cycle.
    // With inject set, a competing start with other operands is raised mid-CALC.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit tc, input bit inject);
        int  k;
        bit  got;
        logic [15:0] exp;
        exp    = ref8(a, b, tc);
        a8     = a;
        b8     = b;
`ifdef SEQ_MULT_SIGNED_EN
        tc8    = tc;
`endif
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        k   = 0;
        got = 0;
        while (!got && k < 20) begin
            if (inject && k == 2) begin
                start8 = 1'b1;
                a8     = 8'd100;
                b8     = 8'd100;
            end
            if (inject && k == 4) start8 = 1'b0;
            tick();
            k++;
            check("w8_busy_done_excl", {63'd0, busy8 & done8}, 64'd0);
            if (done8) got = 1;
            else check("w8_busy_in_calc", {63'd0, busy8}, 64'd1);
        end
        start8 = 1'b0;
        check("w8_latency", 64'(k), 64'd8);
        check("w8_product", {48'd0, p8}, {48'd0, exp});
    endtask

    initial begin
        int order [256];
        int j, tmp, k;
        bit seen_done;
        logic [7:0] ra, rb;
        bit rtc;

        rst    = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
`ifdef SEQ_MULT_SIGNED_EN
        tc4    = 1'b0;
        tc8    = 1'b0;
`endif
        #2;
        check("rst_busy4", {63'd0, busy4}, 64'd0);
        check("rst_done4", {63'd0, done4}, 64'd0);
        check("rst_p4",    {56'd0, p4},    64'd0);
        check("rst_busy8", {63'd0, busy8}, 64'd0);
        check("rst_done8", {63'd0, done8}, 64'd0);
        check("rst_p8",    {48'd0, p8},    64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // WIDTH=4: 15*15, then p holds
        op4(4'd15, 4'd15);
        tick();
        check("w4_done_single", {63'd0, done4}, 64'd0);
        check("w4_idle_busy",   {63'd0, busy4}, 64'd0);
        tick();
        check("w4_p_hold",      {56'd0, p4},    64'd225);

        // WIDTH=8 back-to-back: issued on each done cycle
        op8(8'd9,   8'd7,   1'b0, 1'b0);
        op8(8'd0,   8'd200, 1'b0, 1'b0);
        op8(8'd255, 8'd255, 1'b0, 1'b0);
        tick();
        check("w8_b2b_end_done", {63'd0, done8}, 64'd0);

        // Start during CALC is ignored
        tick();
        op8(8'd5, 8'd6, 1'b0, 1'b1);
        tick();
        check("w8_ignored_idle", {63'd0, busy8}, 64'd0);
        check("w8_ignored_p",    {48'd0, p8},    64'd30);

        // Asynchronous reset in the middle of CALC
        a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(); tick(); tick();
        #3;
        rst = 1'b1;
        #1;
        check("arst_busy", {63'd0, busy8}, 64'd0);
        check("arst_done", {63'd0, done8}, 64'd0);
        check("arst_p",    {48'd0, p8},    64'd0);
        tick();
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 || busy8) seen_done = 1;
        end
        check("arst_no_done", {63'd0, seen_done}, 64'd0);
        op8(8'd12, 8'd12, 1'b0, 1'b0);
        tick();

`ifdef SEQ_MULT_SIGNED_EN
        op8(8'hFD, 8'd7,   1'b1, 1'b0);
        check("signed_neg21", {48'd0, p8}, 64'h0000_0000_0000_FFEB);
        op8(8'h80, 8'h80,  1'b1, 1'b0);
        check("signed_minsq", {48'd0, p8}, 64'd16384);
        op8(8'hFD, 8'd7,   1'b0, 1'b0);
        check("signed_tc0",   {48'd0, p8}, 64'd1771);
        tick();
`endif

        // WIDTH=4: every operand pair in shuffled order, back to back
        for (int i = 0; i < 256; i++) order[i] = i;
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            tmp = order[i];
            op4(4'(tmp >> 4), 4'(tmp & 15));
        end
        tick();

        // WIDTH=8: random operands
        for (int i = 0; i < 40; i++) begin
            ra  = 8'($urandom_range(255, 0));
            rb  = 8'($urandom_range(255, 0));
`ifdef SEQ_MULT_SIGNED_EN
            rtc = 1'($urandom_range(1, 0));
`else
            rtc = 1'b0;
`endif
            op8(ra, rb, rtc, 1'b0);
            k = $urandom_range(2, 0);
            for (int w = 0; w < k; w++) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
